conf_sys_sched: RTL and testbench
=================================

// Module: conf_sys_sched
// PURPOSE
//  Scheduler feeding the two-lane sparse MAC array (conf_sys) from a column-ordered (CSC) nonzero stream.
//  Pairs same-column nonzeros into lane1/lane2 beats sharing one vec operand.
//  Pads odd columns with a zero lane2. Generates per-column tag parity.
//  Stalls on the datapath overlap signal and counts issued beats and stall cycles.
// PARAMETERS
//  DATA_W  32  width of val/vec operands
//  IDX_W   12  width of row index
//  CNT_W   16  width of beat/stall counters (saturating)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       begin a new matrix pass; honoured only in IDLE/DONE
//  in_valid     in   1       input nonzero valid
//  in_ready     out  1       scheduler accepts the nonzero this cycle
//  in_val       in   DATA_W  nonzero value
//  in_row       in   IDX_W   row index of nonzero
//  in_vec       in   DATA_W  vector element for this column; sampled from lane-A element only
//  in_col_last  in   1       last nonzero of current column
//  in_last      in   1       last nonzero of matrix (implies col_last)
//  val1/val2    out  DATA_W  lane operands to conf_sys
//  rowIdx1/2    out  IDX_W   lane row indices
//  tag1/tag2    out  1       lane column-parity tags
//  vec          out  DATA_W  shared vector operand
//  issue        out  1       one-cycle strobe: beat on lane outputs consumed this cycle
//  overlap      in   1       datapath conflict/back-pressure; holds current beat
//  busy         out  1       high in LOAD_A/LOAD_B/ISSUE
//  done         out  1       pass complete; held until next start
//  beat_cnt     out  CNT_W   beats issued this pass
//  stall_cnt    out  CNT_W   cycles ISSUE was held by overlap
// BEHAVIOUR
//  Reset: all outputs 0, in_ready 0, col_tag 0, state IDLE.
//  FSM: IDLE, LOAD_A, LOAD_B, ISSUE, DONE.
//  - IDLE/DONE: start -> clear beat_cnt/stall_cnt/col_tag, deassert done, go to LOAD_A. start in other states is ignored.
//  - LOAD_A: in_ready=1. On handshake, capture A (val,row,vec,flags).
//    If col_last|last, load outputs with lane2 = {val 0, row 0, tag 0} and go to ISSUE. Otherwise go to LOAD_B.
//  - LOAD_B: in_ready=1. On handshake, capture B and load both lanes; go to ISSUE. B's in_vec is ignored.
//  - ISSUE: in_ready=0. issue = ~overlap.
//    overlap=1: hold outputs, stall_cnt+1 (saturate).
//    On issue: beat_cnt+1 (saturate). If beat carried col_last, toggle col_tag. Next state is DONE if beat carried last, else LOAD_A.
//  tag1 = col_tag for the beat. tag2 = col_tag when lane2 is occupied, else 0.
//  Data outputs are registered and change only on entry to ISSUE. They hold their value after issue.
//  Latency: single-lane beat issues on cycle N+1 after A accepted at N. A pair issues on N+1 after B accepted at N.
//  Throughput: at most one beat per 3 cycles (pair) or per 2 cycles (single).
//  Reset mid-pass aborts immediately; the partial beat is discarded.
// CONFIGURATION
//  SAME_ROW_SPLIT_EN defined:
//    If A.row==B.row at LOAD_B capture, issue A alone (lane2 zeroed), then B alone in lane1 as a second beat without new input.
//    col_tag toggles only after the B beat, if B carries col_last.
//  SAME_ROW_SPLIT_EN undefined: pair is issued as-is; the datapath overlap stall is the only protection.
// STRUCTURE
//  Shared package: state enum, lane-record struct {val,row,tag,col_last,last}, zero-lane constant.
//  One sub-module is natural: sat_counter (CNT_W, inc, clr), instanced twice.
// TESTING
//  Reset low mid-ISSUE -> all outputs 0 and state IDLE on the next edge; done=0.
//  start; nonzeros (0xABCDE,r0x123), (0x54321,r0x456,col_last), vec 0x1234 -> one beat: val1=ABCDE, val2=54321, rowIdx 123/456, tag1=tag2=0, vec=1234.
//  Column with one nonzero (0x98765,r0x789,col_last,last) -> val1=98765, val2=0, rowIdx2=0, tag1=1, tag2=0; done=1 next cycle; beat_cnt=2.
//  overlap high 3 cycles during ISSUE -> outputs stable, issue=0, stall_cnt=3; issue pulses on first cycle overlap=0.
//  SAME_ROW_SPLIT_EN, pair both on row 0x010 -> two beats of lane1-only; beat_cnt+2. Macro off -> one paired beat.
//  start asserted while busy -> ignored; counters unchanged; pass completes normally.

Source files
------------

// File: rtl/conf_sys_sched_pkg.sv
// Shared types for the conf_sys CSC scheduler: FSM states, lane record and helpers.
// Lane records are sized to the package maxima; module parameters must not exceed them.
package conf_sys_sched_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_IDX_W  = 12;
   localparam int PKG_CNT_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] val;
      logic [PKG_IDX_W-1:0]  row;
      logic                  tag;
      logic                  col_last;
      logic                  last;
   } lane_t;

   localparam lane_t LANE_ZERO = '0;

   function automatic lane_t make_lane(input logic [PKG_DATA_W-1:0] val,
                                       input logic [PKG_IDX_W-1:0]  row,
                                       input logic                  tag,
                                       input logic                  col_last,
                                       input logic                  last);
      lane_t l;
      l.val      = val;
      l.row      = row;
      l.tag      = tag;
      l.col_last = col_last | last;
      l.last     = last;
      return l;
   endfunction

endpackage

// File: rtl/conf_sys_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/conf_sys_sched.sv
// Pairs same-column CSC nonzeros into two-lane beats for conf_sys, with column tag parity.
// Optional SAME_ROW_SPLIT_EN: a same-row pair is issued as two lane1-only beats.
module conf_sys_sched
   import conf_sys_sched_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int IDX_W  = PKG_IDX_W,
   parameter int CNT_W  = PKG_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_val,
   input  logic [IDX_W-1:0]  in_row,
   input  logic [DATA_W-1:0] in_vec,
   input  logic              in_col_last,
   input  logic              in_last,
   output logic [DATA_W-1:0] val1,
   output logic [DATA_W-1:0] val2,
   output logic [IDX_W-1:0]  rowIdx1,
   output logic [IDX_W-1:0]  rowIdx2,
   output logic              tag1,
   output logic              tag2,
   output logic [DATA_W-1:0] vec,
   output logic              issue,
   input  logic              overlap,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t            state_reg, state_next;
   lane_t             lane1_reg, lane1_next;
   lane_t             lane2_reg, lane2_next;
   lane_t             a_reg, a_next;
   logic [DATA_W-1:0] vec_reg, vec_next;
   logic [DATA_W-1:0] a_vec_reg, a_vec_next;
   logic              col_tag_reg, col_tag_next;
`ifdef SAME_ROW_SPLIT_EN
   lane_t             pend_reg, pend_next;
   logic              split_reg, split_next;
`endif

   lane_t             in_lane;
   logic              cnt_clr;
   logic [1:0]        cnt_inc;
   logic [CNT_W-1:0]  cnt_val [2];

   assign in_lane = make_lane(PKG_DATA_W'(in_val), PKG_IDX_W'(in_row),
                              col_tag_reg, in_col_last, in_last);

   always_comb begin
      state_next   = state_reg;
      lane1_next   = lane1_reg;
      lane2_next   = lane2_reg;
      a_next       = a_reg;
      vec_next     = vec_reg;
      a_vec_next   = a_vec_reg;
      col_tag_next = col_tag_reg;
      cnt_clr      = 1'b0;
`ifdef SAME_ROW_SPLIT_EN
      pend_next    = pend_reg;
      split_next   = split_reg;
`endif
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               cnt_clr      = 1'b1;
               col_tag_next = 1'b0;
               state_next   = ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            if (in_valid) begin
               if (in_lane.col_last) begin
                  lane1_next = in_lane;
                  lane2_next = LANE_ZERO;
                  vec_next   = in_vec;
                  state_next = ST_ISSUE;
               end else begin
                  a_next     = in_lane;
                  a_vec_next = in_vec;
                  state_next = ST_LOAD_B;
               end
            end
         end
         ST_LOAD_B: begin
            // Lane B rides on lane A's vector element; its own in_vec is ignored.
            if (in_valid) begin
               lane1_next = a_reg;
               lane2_next = in_lane;
               vec_next   = a_vec_reg;
               state_next = ST_ISSUE;
`ifdef SAME_ROW_SPLIT_EN
               if (in_lane.row == a_reg.row) begin
                  lane2_next = LANE_ZERO;
                  pend_next  = in_lane;
                  split_next = 1'b1;
               end
`endif
            end
         end
         ST_ISSUE: begin
            if (!overlap) begin
`ifdef SAME_ROW_SPLIT_EN
               // First half of a split pair: B follows in lane1 without new input.
               if (split_reg) begin
                  lane1_next = pend_reg;
                  lane2_next = LANE_ZERO;
                  split_next = 1'b0;
               end else
`endif
               begin
                  if (lane1_reg.col_last || lane2_reg.col_last) begin
                     col_tag_next = ~col_tag_reg;
                  end
                  if (lane1_reg.last || lane2_reg.last) begin
                     state_next = ST_DONE;
                  end else begin
                     state_next = ST_LOAD_A;
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         lane1_reg   <= LANE_ZERO;
         lane2_reg   <= LANE_ZERO;
         a_reg       <= LANE_ZERO;
         vec_reg     <= '0;
         a_vec_reg   <= '0;
         col_tag_reg <= 1'b0;
`ifdef SAME_ROW_SPLIT_EN
         pend_reg    <= LANE_ZERO;
         split_reg   <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         lane1_reg   <= lane1_next;
         lane2_reg   <= lane2_next;
         a_reg       <= a_next;
         vec_reg     <= vec_next;
         a_vec_reg   <= a_vec_next;
         col_tag_reg <= col_tag_next;
`ifdef SAME_ROW_SPLIT_EN
         pend_reg    <= pend_next;
         split_reg   <= split_next;
`endif
      end
   end

   // Counter 0 counts issued beats, counter 1 counts overlap-held ISSUE cycles.
   assign cnt_inc[0] = issue;
   assign cnt_inc[1] = (state_reg == ST_ISSUE) && overlap;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (cnt_clr),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   assign beat_cnt  = cnt_val[0];
   assign stall_cnt = cnt_val[1];

   assign in_ready = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
   assign busy     = in_ready || (state_reg == ST_ISSUE);
   assign done     = (state_reg == ST_DONE);
   assign issue    = (state_reg == ST_ISSUE) && !overlap;

   assign val1    = lane1_reg.val[DATA_W-1:0];
   assign val2    = lane2_reg.val[DATA_W-1:0];
   assign rowIdx1 = lane1_reg.row[IDX_W-1:0];
   assign rowIdx2 = lane2_reg.row[IDX_W-1:0];
   assign tag1    = lane1_reg.tag;
   assign tag2    = lane2_reg.tag;
   assign vec     = vec_reg;

endmodule

// File: tb/tb_conf_sys_sched.sv
// Directed self-checking bench for conf_sys_sched (default build or SAME_ROW_SPLIT_EN).
module tb_conf_sys_sched;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 12;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_val;
   logic [IDX_W-1:0]  in_row;
   logic [DATA_W-1:0] in_vec;
   logic              in_col_last;
   logic              in_last;
   logic [DATA_W-1:0] val1, val2, vec;
   logic [IDX_W-1:0]  rowIdx1, rowIdx2;
   logic              tag1, tag2, issue, overlap, busy, done;
   logic [CNT_W-1:0]  beat_cnt, stall_cnt;

   int errors = 0;
   int checks = 0;

   conf_sys_sched #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_val(in_val), .in_row(in_row), .in_vec(in_vec),
      .in_col_last(in_col_last), .in_last(in_last),
      .val1(val1), .val2(val2), .rowIdx1(rowIdx1), .rowIdx2(rowIdx2),
      .tag1(tag1), .tag2(tag2), .vec(vec), .issue(issue), .overlap(overlap),
      .busy(busy), .done(done), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offers one nonzero and returns #1 after the accepting edge.
   task automatic send(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] r,
                       input logic [DATA_W-1:0] vc, input logic cl, input logic lst);
      int n;
      in_val = v; in_row = r; in_vec = vc; in_col_last = cl; in_last = lst;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("ready_wait", 64'(n < 20), 64'd1);
      tick();
      in_valid = 1'b0;
      $display("txn: val=%0h row=%0h vec=%0h col_last=%0b last=%0b", v, r, vc, cl, lst);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; overlap = 1'b0;
      in_val = '0; in_row = '0; in_vec = '0; in_col_last = 1'b0; in_last = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_val1", 64'(val1), 64'd0);
      chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      reset = 1'b1;
      tick();

      // Reset asserted while a beat is held in ISSUE
      pulse_start();
      chk("load_a_ready", 64'(in_ready), 64'd1);
      chk("load_a_busy", 64'(busy), 64'd1);
      overlap = 1'b1;
      send(32'h111, 12'h001, 32'h5, 1'b1, 1'b1);
      chk("midrst_pre_val1", 64'(val1), 64'h111);
      chk("midrst_pre_issue", 64'(issue), 64'd0);
      reset = 1'b0;
      tick();
      chk("midrst_val1", 64'(val1), 64'd0);
      chk("midrst_vec", 64'(vec), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_stall", 64'(stall_cnt), 64'd0);
      overlap = 1'b0;
      reset = 1'b1;
      tick();

      // Paired column then single-nonzero column
      pulse_start();
      send(32'hABCDE, 12'h123, 32'h1234, 1'b0, 1'b0);
      chk("pair_no_issue_yet", 64'(issue), 64'd0);
      send(32'h54321, 12'h456, 32'h9999, 1'b1, 1'b0);
      chk("pair_val1", 64'(val1), 64'hABCDE);
      chk("pair_val2", 64'(val2), 64'h54321);
      chk("pair_row1", 64'(rowIdx1), 64'h123);
      chk("pair_row2", 64'(rowIdx2), 64'h456);
      chk("pair_tag1", 64'(tag1), 64'd0);
      chk("pair_tag2", 64'(tag2), 64'd0);
      chk("pair_vec", 64'(vec), 64'h1234);
      chk("pair_issue", 64'(issue), 64'd1);
      tick();
      chk("pair_beat_cnt", 64'(beat_cnt), 64'd1);
      chk("pair_hold_val1", 64'(val1), 64'hABCDE);
      chk("pair_back_load_a", 64'(in_ready), 64'd1);
      send(32'h98765, 12'h789, 32'h4321, 1'b1, 1'b1);
      chk("single_val1", 64'(val1), 64'h98765);
      chk("single_val2", 64'(val2), 64'd0);
      chk("single_row2", 64'(rowIdx2), 64'd0);
      chk("single_tag1", 64'(tag1), 64'd1);
      chk("single_tag2", 64'(tag2), 64'd0);
      chk("single_vec", 64'(vec), 64'h4321);
      chk("single_issue", 64'(issue), 64'd1);
      tick();
      chk("single_done", 64'(done), 64'd1);
      chk("single_beat_cnt", 64'(beat_cnt), 64'd2);
      chk("single_busy", 64'(busy), 64'd0);
      tick();
      chk("done_held", 64'(done), 64'd1);

      // Three overlap cycles during ISSUE
      pulse_start();
      chk("restart_beat_cnt", 64'(beat_cnt), 64'd0);
      chk("restart_done", 64'(done), 64'd0);
      overlap = 1'b1;
      send(32'h5A5A, 12'h0AA, 32'h7, 1'b1, 1'b1);
      chk("ovl_issue_c1", 64'(issue), 64'd0);
      tick();
      chk("ovl_issue_c2", 64'(issue), 64'd0);
      chk("ovl_val1_c2", 64'(val1), 64'h5A5A);
      tick();
      chk("ovl_issue_c3", 64'(issue), 64'd0);
      chk("ovl_row1_c3", 64'(rowIdx1), 64'h0AA);
      tick();
      overlap = 1'b0;
      #1;
      chk("ovl_release_issue", 64'(issue), 64'd1);
      chk("ovl_stall_cnt", 64'(stall_cnt), 64'd3);
      chk("ovl_val1_stable", 64'(val1), 64'h5A5A);
      tick();
      chk("ovl_done", 64'(done), 64'd1);
      chk("ovl_beat_cnt", 64'(beat_cnt), 64'd1);
      chk("ovl_stall_final", 64'(stall_cnt), 64'd3);

      // Pair sharing row 0x010
      pulse_start();
      chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);
      send(32'h1, 12'h010, 32'h22, 1'b0, 1'b0);
      send(32'h2, 12'h010, 32'h33, 1'b1, 1'b1);
`ifdef SAME_ROW_SPLIT_EN
      chk("split_a_val1", 64'(val1), 64'h1);
      chk("split_a_val2", 64'(val2), 64'd0);
      chk("split_a_row1", 64'(rowIdx1), 64'h010);
      chk("split_a_issue", 64'(issue), 64'd1);
      tick();
      chk("split_b_val1", 64'(val1), 64'h2);
      chk("split_b_val2", 64'(val2), 64'd0);
      chk("split_b_row1", 64'(rowIdx1), 64'h010);
      chk("split_b_tag1", 64'(tag1), 64'd0);
      chk("split_b_vec", 64'(vec), 64'h22);
      chk("split_b_issue", 64'(issue), 64'd1);
      chk("split_b_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("split_done", 64'(done), 64'd1);
      chk("split_beat_cnt", 64'(beat_cnt), 64'd2);
`else
      chk("same_val1", 64'(val1), 64'h1);
      chk("same_val2", 64'(val2), 64'h2);
      chk("same_row2", 64'(rowIdx2), 64'h010);
      chk("same_tag1", 64'(tag1), 64'd0);
      chk("same_vec", 64'(vec), 64'h22);
      chk("same_issue", 64'(issue), 64'd1);
      tick();
      chk("same_done", 64'(done), 64'd1);
      chk("same_beat_cnt", 64'(beat_cnt), 64'd1);
`endif

      // start while busy is ignored
      pulse_start();
      send(32'h3, 12'h020, 32'h44, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      chk("busy_start_ready", 64'(in_ready), 64'd1);
      chk("busy_start_beat", 64'(beat_cnt), 64'd0);
      send(32'h4, 12'h021, 32'h55, 1'b1, 1'b1);
      chk("busy_start_issue", 64'(issue), 64'd1);
      chk("busy_start_val2", 64'(val2), 64'h4);
      start = 1'b0;
      tick();
      chk("busy_start_done", 64'(done), 64'd1);
      chk("busy_start_beat_cnt", 64'(beat_cnt), 64'd1);
      chk("busy_start_stall", 64'(stall_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
